// File: rtl/interrupt_request.sv
`default_nettype none
// ============================================================================
//  Module   : interrupt_request
//  Purpose  : Interrupt Request Register (IRR) of an 8259A-compatible PIC.
//             Samples IR7..IR0 every clock and records pending requests in
//             either level-sensitive or edge-triggered mode (ICW1 LTIM).
//  Revision : 1.0 - initial release
// ============================================================================
module interrupt_request (
  input  logic       clk,
  input  logic       reset,
  input  logic       Level_OR_Edge_trigger,
  input  logic [7:0] Int_Req_Pins,
  input  logic [7:0] Clear_Int_Req,
  output logic [7:0] Int_Req_Reg,
  output logic       Int_Req_Any
);

  // Reset value of the previous-pin register. All ones, so a pin that is
  // already high when reset releases does not look like a fresh edge.
  localparam logic [7:0] C_PREV_RESET = 8'hFF;

  logic [7:0] prev_pins_q;
  logic [7:0] prev_pins_d;
  logic [7:0] irr_q;
  logic [7:0] irr_d;
  logic [7:0] w_rise;

  // Low-to-high transition seen between the last sample and this one.
  assign w_rise = Int_Req_Pins & ~prev_pins_q;

  // Next-state logic: level mode follows the pins (acknowledge clears cannot
  // stick while a pin is high); edge mode sets on a rising edge, holds while
  // the pin stays high, and the acknowledge clear wins over set and hold.
  always_comb begin
    prev_pins_d = Int_Req_Pins;
    irr_d       = irr_q;
    if (Level_OR_Edge_trigger) begin
      irr_d = Int_Req_Pins;
    end else begin
      irr_d = (w_rise | (irr_q & Int_Req_Pins)) & ~Clear_Int_Req;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      irr_q       <= 8'h00;
      prev_pins_q <= C_PREV_RESET;
    end else begin
      irr_q       <= irr_d;
      prev_pins_q <= prev_pins_d;
    end
  end

  assign Int_Req_Reg = irr_q;
  assign Int_Req_Any = |irr_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_request.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interrupt_request
//  Purpose  : Directed self-checking bench for interrupt_request.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_request;

  logic       clk;
  logic       reset;
  logic       Level_OR_Edge_trigger;
  logic [7:0] Int_Req_Pins;
  logic [7:0] Clear_Int_Req;
  logic [7:0] Int_Req_Reg;
  logic       Int_Req_Any;

  int n_checks = 0;
  int n_pass   = 0;

  interrupt_request dut (
    .clk                   (clk),
    .reset                 (reset),
    .Level_OR_Edge_trigger (Level_OR_Edge_trigger),
    .Int_Req_Pins          (Int_Req_Pins),
    .Clear_Int_Req         (Clear_Int_Req),
    .Int_Req_Reg           (Int_Req_Reg),
    .Int_Req_Any           (Int_Req_Any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset                 = 1'b1;
    Level_OR_Edge_trigger = 1'b0;
    Int_Req_Pins          = 8'hAA;
    Clear_Int_Req         = 8'h00;

    // Reset with pins high
    tick(); tick();
    check_eq("reset_reg", Int_Req_Reg, 8'h00);
    check_eq("reset_any", {7'd0, Int_Req_Any}, 8'h00);
    reset = 1'b0;
    tick();
    check_eq("post_reset_edge_hold1", Int_Req_Reg, 8'h00);
    tick();
    check_eq("post_reset_edge_hold2", Int_Req_Reg, 8'h00);

    // Level sense
    Level_OR_Edge_trigger = 1'b1;
    Int_Req_Pins = 8'h00; tick();
    check_eq("lvl_zero", Int_Req_Reg, 8'h00);
    Int_Req_Pins = 8'hAA; tick();
    check_eq("lvl_set", Int_Req_Reg, 8'hAA);
    check_eq("lvl_any1", {7'd0, Int_Req_Any}, 8'h01);
    Int_Req_Pins = 8'h00; tick();
    check_eq("lvl_drop", Int_Req_Reg, 8'h00);
    check_eq("lvl_any0", {7'd0, Int_Req_Any}, 8'h00);
    Int_Req_Pins = 8'hAA; tick();
    Clear_Int_Req = 8'hFF; tick();
    check_eq("lvl_clear_no_effect", Int_Req_Reg, 8'hAA);
    Clear_Int_Req = 8'h00;

    // Edge sense
    Level_OR_Edge_trigger = 1'b0;
    Int_Req_Pins = 8'h00; tick();
    check_eq("edge_zero", Int_Req_Reg, 8'h00);
    Int_Req_Pins = 8'h55; tick();
    check_eq("edge_set55", Int_Req_Reg, 8'h55);
    Int_Req_Pins = 8'hAA; tick();
    check_eq("edge_swapAA", Int_Req_Reg, 8'hAA);

    // Acknowledge clear
    Clear_Int_Req = 8'h02; tick();
    check_eq("ack_clear", Int_Req_Reg, 8'hA8);
    Clear_Int_Req = 8'h00; tick();
    check_eq("ack_stays1", Int_Req_Reg, 8'hA8);
    tick();
    check_eq("ack_stays2", Int_Req_Reg, 8'hA8);
    Int_Req_Pins = 8'hA8; tick();
    check_eq("ack_pin_low", Int_Req_Reg, 8'hA8);
    Int_Req_Pins = 8'hAA; tick();
    check_eq("ack_reedge", Int_Req_Reg, 8'hAA);

    // Simultaneous edge and clear
    Int_Req_Pins = 8'h00; tick();
    check_eq("sim_zero", Int_Req_Reg, 8'h00);
    Int_Req_Pins  = 8'h18;
    Clear_Int_Req = 8'h08; tick();
    check_eq("sim_clear_wins", Int_Req_Reg, 8'h10);
    Clear_Int_Req = 8'h00; tick();
    check_eq("sim_no_reset_bit3", Int_Req_Reg, 8'h10);

    // Mode switch level -> edge
    Level_OR_Edge_trigger = 1'b1;
    Int_Req_Pins = 8'h0F; tick();
    check_eq("msw_level", Int_Req_Reg, 8'h0F);
    Level_OR_Edge_trigger = 1'b0; tick();
    check_eq("msw_hold", Int_Req_Reg, 8'h0F);
    Int_Req_Pins = 8'h1F; tick();
    check_eq("msw_raise4", Int_Req_Reg, 8'h1F);
    Int_Req_Pins = 8'h1E; tick();
    check_eq("msw_drop0", Int_Req_Reg, 8'h1E);

    // Reset mid-request, then edge->level
    reset = 1'b1; tick();
    check_eq("mid_reset", Int_Req_Reg, 8'h00);
    reset = 1'b0; tick();
    check_eq("mid_reset_no_edge", Int_Req_Reg, 8'h00);
    Level_OR_Edge_trigger = 1'b1; tick();
    check_eq("to_level_follow", Int_Req_Reg, 8'h1E);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
